prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader, directly upstream of the instruction memory and the CPU core.
- Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset while loading; releases it once the declared number of words has been written.
- Stream format: 2-byte word count N (high byte first), then N words, each high byte first.

Parameters:
- ADDR_W, 10, instruction memory address width (matches the 10-bit PC slice used by the instruction memory).
- WORD_W, 16, instruction word width; fixed at 16 (two bytes per word).
- MAX_WORDS, 1024, largest legal N; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  incoming byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  write data.
- cpu_reset  out  1  hold-reset to the CPU core; high until the load completes.
- busy  out  1  load in progress.
- done  out  1  load completed successfully.
- err_overflow  out  1  declared N exceeded MAX_WORDS.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- All outputs registered.
- Reset values: byte_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, busy 0, done 0, err_overflow 0, word_count 0, state IDLE.
- Handshake: a byte transfers on a cycle with byte_valid && byte_ready. Bytes presented while byte_ready=0 are ignored, and the source must hold them. byte_ready is high only in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
- IDLE:
  - start=1 -> LEN_HI. Set busy=1, clear word_count/done/err_overflow, cpu_reset=1.
- LEN_HI:
  - On transfer, latch N[15:8] -> LEN_LO.
- LEN_LO:
  - On transfer, latch N[7:0], then decide using the full 16-bit N:
    - N=0 -> DONE.
    - N>MAX_WORDS -> ERROR.
    - Otherwise -> DATA_HI.
- DATA_HI:
  - On transfer, latch wdata[15:8] -> DATA_LO.
- DATA_LO:
  - On transfer, latch wdata[7:0] -> WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=assembled word.
  - word_count increments at the end of the cycle.
  - If the incremented count == N -> DONE, else -> DATA_HI.
- Timing:
  - mem_we asserts the cycle after the low-byte transfer.
  - Peak throughput is 2 bytes per 3 cycles.
  - mem_we is 0 in every state except WRITE.
- DONE:
  - busy=0, done=1, cpu_reset=0.
  - mem_addr/mem_wdata hold their last values.
  - start=1 -> LEN_HI with cpu_reset=1 again (reload).
- ERROR:
  - busy=0, err_overflow=1, cpu_reset stays 1, no memory writes.
  - start=1 -> LEN_HI (retry).
- start while in LEN_HI..WRITE is ignored.
- Reset mid-load:
  - Returns to IDLE with reset values; cpu_reset=1.
  - A partially formed word is discarded.
  - Words already written to memory are not cleared.
- Load of exactly N=MAX_WORDS=1024:
  - Last write is to address 1023.
  - word_count ends at 1024 (hence the ADDR_W+1 width); no address wrap occurs.
- byte_valid held continuously: the loader stalls the source during WRITE via byte_ready=0; no byte is lost or duplicated.

Test Plan:
- Reset, start, then stream 00 02 12 34 AB CD with byte_valid always high:
  - mem_we pulses exactly twice: addr 0 data 0x1234, then addr 1 data 0xABCD.
  - Then done=1, cpu_reset=0, word_count=2, busy=0.
- Stream 00 00 after start:
  - DONE two transfers later, no mem_we, cpu_reset=0, word_count=0.
- Stream 04 01 (N=1025):
  - ERROR with err_overflow=1, cpu_reset=1, no mem_we.
  - A later start followed by 00 01 FF EE writes 0xFFEE to addr 0 and reaches done.
- Full N=1024 load of incrementing words:
  - Final write is addr 1023, word_count=1024, done=1.
  - Memory readback matches every word.
- Mid-word reset:
  - After 00 03 11 22 33, assert reset for one cycle.
  - Required: outputs at reset values, cpu_reset=1, no write of a word beginning 0x33.
  - A fresh load then writes from addr 0.
- Random byte_valid gaps plus start pulses during DATA states:
  - Loader ignores the start pulses.
  - Written words are identical to the gap-free run.

Source files
------------

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Takes a byte stream over a valid/ready handshake,
// assembles 16-bit instruction words (high byte first) and writes them
// sequentially into instruction memory starting at address 0. The stream
// begins with a 2-byte word count N (high byte first). The CPU core is held
// in reset until all N words have been written.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   start         single-cycle pulse, begins a (re)load from IDLE/DONE/ERROR
//   byte_valid    source presents a byte on byte_data
//   byte_data     incoming byte
//   byte_ready    loader accepts a byte this cycle
//   mem_we        instruction memory write strobe (one cycle per word)
//   mem_addr      instruction memory write address
//   mem_wdata     instruction memory write data
//   cpu_reset     hold-reset to the CPU; drops only after a successful load
//   busy          load in progress
//   done          last load completed successfully
//   err_overflow  declared N exceeded MAX_WORDS
//   word_count    words written in the current or last load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int WORD_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MAX_WORDS_U = MAX_WORDS;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          hi_q, hi_d;
    logic                byte_ready_q, byte_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;

    logic                xfer;
    logic [15:0]         len_full;
    logic [ADDR_W:0]     count_inc;

    // byte_ready is registered, so it already reflects the current state.
    assign xfer      = byte_valid && byte_ready_q;
    assign len_full  = {len_q[15:8], byte_data};
    assign count_inc = word_count_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        len_d        = len_q;
        hi_d         = hi_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_reset_d  = cpu_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        word_count_d = word_count_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d      = S_LEN_HI;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                    cpu_reset_d  = 1'b1;
                    word_count_d = '0;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = byte_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else if (32'(len_full) > MAX_WORDS_U) begin
                        // CPU stays in reset: no usable program was loaded.
                        state_d = S_ERROR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = byte_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    // word_count has not advanced yet, so it is this word's address.
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_count_q[ADDR_W-1:0];
                    mem_wdata_d = {hi_q, byte_data};
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                word_count_d = count_inc;
                if (32'(count_inc) == 32'(len_q)) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    cpu_reset_d = 1'b0;
                end else begin
                    state_d = S_DATA_HI;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready follows the next state so it is valid in the same cycle the
    // state register enters a byte-accepting state; WRITE stalls the source.
    assign byte_ready_d = (state_d == S_LEN_HI)  || (state_d == S_LEN_LO) ||
                          (state_d == S_DATA_HI) || (state_d == S_DATA_LO);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            hi_q         <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader: a table of complete byte streams with
// their expected memory writes and final status, followed by hand-written
// sequences for write timing, a full 1024-word load, reset mid-word, and
// source gaps with stray start pulses.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err_overflow;
    logic [10:0] word_count;

    prog_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] mem [0:1023];

    // Write monitor: outputs are registered, so sampling at negedge is stable.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wq.push_back('{mem_addr, mem_wdata});
            mem[mem_addr] = mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic push(input logic [7:0] b, input bit gap, input bit pulse);
        int budget;
        if (gap) begin
            byte_valid = 1'b0;
            start      = pulse;
            @(negedge clk);
            start      = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        budget     = 0;
        while (byte_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: byte_ready stayed low for byte 0x%0h", b);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        int          exp_writes;
        logic [9:0]  f_addr;
        logic [15:0] f_data;
        logic [9:0]  l_addr;
        logic [15:0] l_data;
        bit          exp_done;
        bit          exp_err;
        bit          exp_cpu;
        int          exp_wc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{6, 64'h0002_1234_ABCD_0000, 2, 10'd0, 16'h1234, 10'd1, 16'hABCD, 1'b1, 1'b0, 1'b0, 2};
        vecs[1] = '{2, 64'h0000_0000_0000_0000, 0, 10'd0, 16'h0000, 10'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{2, 64'h0401_0000_0000_0000, 0, 10'd0, 16'h0000, 10'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 0};
        vecs[3] = '{4, 64'h0001_FFEE_0000_0000, 1, 10'd0, 16'hFFEE, 10'd0, 16'hFFEE, 1'b1, 1'b0, 1'b0, 1};
        vecs[4] = '{8, 64'h0003_0102_0304_0506, 3, 10'd0, 16'h0102, 10'd2, 16'h0506, 1'b1, 1'b0, 1'b0, 3};
        vecs[5] = '{2, 64'hFFFF_0000_0000_0000, 0, 10'd0, 16'h0000, 10'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 0};

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
        check("rst_cpu_reset",  32'(cpu_reset),  32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_err",        32'(err_overflow), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven loads, byte_valid held high throughout
        for (int v = 0; v < 6; v++) begin
            logic [63:0] bs;
            bs = vecs[v].bytes;
            wq.delete();
            pulse_start();
            check($sformatf("v%0d_busy_at_start", v), 32'(busy), 32'd1);
            for (int k = 0; k < vecs[v].nb; k++)
                push(bs[63-8*k -: 8], 1'b0, 1'b0);
            byte_valid = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_n_writes", v), 32'(wq.size()), 32'(vecs[v].exp_writes));
            if (vecs[v].exp_writes > 0 && wq.size() > 0) begin
                check($sformatf("v%0d_first_addr", v), 32'(wq[0].a), 32'(vecs[v].f_addr));
                check($sformatf("v%0d_first_data", v), 32'(wq[0].d), 32'(vecs[v].f_data));
                check($sformatf("v%0d_last_addr", v),  32'(wq[wq.size()-1].a), 32'(vecs[v].l_addr));
                check($sformatf("v%0d_last_data", v),  32'(wq[wq.size()-1].d), 32'(vecs[v].l_data));
            end
            check($sformatf("v%0d_done", v),       32'(done),         32'(vecs[v].exp_done));
            check($sformatf("v%0d_err", v),        32'(err_overflow), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_cpu_reset", v),  32'(cpu_reset),    32'(vecs[v].exp_cpu));
            check($sformatf("v%0d_busy", v),       32'(busy),         32'd0);
            check($sformatf("v%0d_word_count", v), 32'(word_count),   32'(vecs[v].exp_wc));
            check($sformatf("v%0d_byte_ready", v), 32'(byte_ready),   32'd0);
        end

        // Write timing: mem_we the cycle after the low byte, ready low in WRITE
        wq.delete();
        pulse_start();
        push(8'h00, 1'b0, 1'b0);
        push(8'h01, 1'b0, 1'b0);
        push(8'hAB, 1'b0, 1'b0);
        byte_valid = 1'b1;
        byte_data  = 8'hCD;
        check("t_ready_data_lo", 32'(byte_ready), 32'd1);
        @(negedge clk);
        check("t_we_write",      32'(mem_we),     32'd1);
        check("t_addr_write",    32'(mem_addr),   32'd0);
        check("t_data_write",    32'(mem_wdata),  32'hABCD);
        check("t_ready_write",   32'(byte_ready), 32'd0);
        check("t_cpu_rst_write", 32'(cpu_reset),  32'd1);
        check("t_busy_write",    32'(busy),       32'd1);
        @(negedge clk);
        check("t_we_after",      32'(mem_we),     32'd0);
        check("t_done_after",    32'(done),       32'd1);
        check("t_cpu_rst_after", 32'(cpu_reset),  32'd0);
        check("t_data_hold",     32'(mem_wdata),  32'hABCD);
        byte_valid = 1'b0;
        @(negedge clk);

        // Full N=1024 load of distinct words
        wq.delete();
        for (int i = 0; i < 1024; i++) mem[i] = 16'hFFFF;
        pulse_start();
        push(8'h04, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] w;
            w = 16'(i) ^ 16'h5A00;
            push(w[15:8], 1'b0, 1'b0);
            push(w[7:0],  1'b0, 1'b0);
        end
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("full_n_writes", 32'(wq.size()), 32'd1024);
        if (wq.size() > 0)
            check("full_last_addr", 32'(wq[wq.size()-1].a), 32'd1023);
        check("full_word_count", 32'(word_count), 32'd1024);
        check("full_done",       32'(done),       32'd1);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (mem[i] !== (16'(i) ^ 16'h5A00)) bad++;
            check("full_readback_bad_words", 32'(bad), 32'd0);
        end

        // Reset in the middle of a word
        wq.delete();
        pulse_start();
        push(8'h00, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        push(8'h11, 1'b0, 1'b0);
        push(8'h22, 1'b0, 1'b0);
        push(8'h33, 1'b0, 1'b0);
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        check("mr_byte_ready", 32'(byte_ready),   32'd0);
        check("mr_mem_we",     32'(mem_we),       32'd0);
        check("mr_mem_addr",   32'(mem_addr),     32'd0);
        check("mr_mem_wdata",  32'(mem_wdata),    32'd0);
        check("mr_cpu_reset",  32'(cpu_reset),    32'd1);
        check("mr_busy",       32'(busy),         32'd0);
        check("mr_done",       32'(done),         32'd0);
        check("mr_err",        32'(err_overflow), 32'd0);
        check("mr_word_count", 32'(word_count),   32'd0);
        repeat (3) @(negedge clk);
        check("mr_n_writes", 32'(wq.size()), 32'd1);
        if (wq.size() > 0)
            check("mr_first_data", 32'(wq[0].d), 32'h1122);
        pulse_start();
        push(8'h00, 1'b0, 1'b0);
        push(8'h01, 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        push(8'h66, 1'b0, 1'b0);
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mr_reload_n_writes", 32'(wq.size()), 32'd2);
        if (wq.size() > 1) begin
            check("mr_reload_addr", 32'(wq[1].a), 32'd0);
            check("mr_reload_data", 32'(wq[1].d), 32'h5566);
        end
        check("mr_reload_done", 32'(done), 32'd1);

        // Source gaps and stray start pulses during the data phase
        wq.delete();
        pulse_start();
        begin
            logic [63:0] bs;
            logic [15:0] exp_w [3];
            bs = 64'h0003_0102_0304_0506;
            exp_w[0] = 16'h0102;
            exp_w[1] = 16'h0304;
            exp_w[2] = 16'h0506;
            for (int k = 0; k < 8; k++) begin
                bit gap;
                gap = (k == 3 || k == 5) ? 1'b1 : 1'($urandom_range(0, 1));
                push(bs[63-8*k -: 8], gap, (k >= 2) && gap);
            end
            byte_valid = 1'b0;
            repeat (4) @(negedge clk);
            check("gap_n_writes", 32'(wq.size()), 32'd3);
            for (int i = 0; i < 3; i++) begin
                if (i < wq.size()) begin
                    check($sformatf("gap_addr%0d", i), 32'(wq[i].a), 32'(i));
                    check($sformatf("gap_data%0d", i), 32'(wq[i].d), 32'(exp_w[i]));
                end
            end
            check("gap_word_count", 32'(word_count), 32'd3);
            check("gap_done",       32'(done),       32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
